phase_accumulator: RTL and testbench

Numerically controlled oscillator core that generates the 8-bit `subsample_phase` ramp consumed directly by the waveform shapers (triangle, and any saw/square stage sharing the phase). Advances a wide phase accumulator once per internal sample tick by a programmable increment. The increment is loaded through a valid/ready handshake and takes effect on a sample-tick boundary. Also provides hard sync and per-cycle wrap/tick strobes for downstream sequencing.

---
 rtl/phase_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_phase_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
// ---------------------------------------------------------------------------
// phase_accumulator
//
// Numerically controlled oscillator core. A wide phase accumulator advances
// once per internal sample tick by the active increment; its top 8 bits form
// the subsample_phase ramp that feeds the waveform shapers. New increments
// arrive through a valid/ready handshake and are committed on a tick
// boundary. Hard sync zeroes the phase on the next tick.
//
// Optional feature (macro PHASE_GLIDE_EN): instead of switching immediately,
// the active increment slews toward the requested value by GLIDE_STEP per
// tick. With the macro undefined, GLIDE_STEP is not used.
//
// Parameters:
//   ACC_W      accumulator width (>= 8, >= INC_W)
//   INC_W      phase increment width, zero-extended into the accumulator
//   DIV        clk cycles per sample tick (>= 2)
//   GLIDE_STEP per-tick slew of the active increment (glide build only)
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   enable          1 = prescaler runs; 0 = prescaler, accumulator, glide hold
//   inc_in          requested phase increment
//   inc_valid       inc_in is valid
//   inc_ready       block can accept a new increment
//   sync            hard-sync request, applied at the next tick
//   subsample_phase top 8 bits of the accumulator
//   phase_wrap      one-cycle pulse on accumulator carry-out
//   sample_tick     one-cycle pulse every DIV enabled cycles
// ---------------------------------------------------------------------------
module phase_accumulator #(
  parameter int ACC_W = 24,
  parameter int INC_W = 16,
  parameter int DIV = 250,
  parameter logic [15:0] GLIDE_STEP = 16'h0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [INC_W-1:0] inc_in,
  input  logic             inc_valid,
  output logic             inc_ready,
  input  logic             sync,
  output logic [7:0]       subsample_phase,
  output logic             phase_wrap,
  output logic             sample_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

`ifdef PHASE_GLIDE_EN
  typedef enum logic [1:0] {ST_READY, ST_PENDING, ST_GLIDING} state_t;
`else
  typedef enum logic [1:0] {ST_READY, ST_PENDING} state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   presc_cnt;
  logic [ACC_W-1:0]   acc;
  logic [INC_W-1:0]   inc_active;
  logic [INC_W-1:0]   inc_pend;
  logic               sync_pend;

  logic               tick;
  logic               sync_now;
  logic [ACC_W:0]     sum_ext;

  assign tick     = enable && (presc_cnt == CNT_LAST);
  // A sync arriving on the tick cycle itself must take effect on that tick.
  assign sync_now = sync_pend || sync;
  assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(inc_active);

  assign subsample_phase = acc[ACC_W-1:ACC_W-8];

  // Prescaler: counts only while enabled and wraps on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (enable) begin
      if (tick) presc_cnt <= '0;
      else      presc_cnt <= presc_cnt + CNT_W'(1);
    end
  end

  // Accumulator and strobes. The add uses inc_active as held before this
  // edge, so a freshly transferred increment first shows on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      phase_wrap  <= 1'b0;
      sample_tick <= 1'b0;
      sync_pend   <= 1'b0;
    end else begin
      sample_tick <= tick;
      phase_wrap  <= 1'b0;
      if (tick) begin
        sync_pend <= 1'b0;
        if (sync_now) begin
          acc <= '0;
        end else begin
          acc        <= sum_ext[ACC_W-1:0];
          phase_wrap <= sum_ext[ACC_W];
        end
      end else if (sync) begin
        sync_pend <= 1'b1;
      end
    end
  end

`ifdef PHASE_GLIDE_EN
  localparam logic [INC_W-1:0] STEP = INC_W'(GLIDE_STEP);

  logic [INC_W-1:0] inc_target;
  logic             glide_up;
  logic [INC_W-1:0] glide_diff;

  assign glide_up   = inc_target > inc_active;
  assign glide_diff = glide_up ? (inc_target - inc_active) : (inc_active - inc_target);
`endif

  // Increment handshake FSM. inc_ready is registered alongside the state so
  // it drops on the accepting edge and rises on the committing tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_READY;
      inc_ready  <= 1'b1;
      inc_pend   <= '0;
      inc_active <= '0;
`ifdef PHASE_GLIDE_EN
      inc_target <= '0;
`endif
    end else begin
      unique case (state)
        ST_READY: begin
          // An accept coinciding with a tick waits for the following tick.
          if (inc_valid) begin
            inc_pend  <= inc_in;
            inc_ready <= 1'b0;
            state     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (tick) begin
`ifdef PHASE_GLIDE_EN
            inc_target <= inc_pend;
            state      <= ST_GLIDING;
`else
            inc_active <= inc_pend;
            inc_ready  <= 1'b1;
            state      <= ST_READY;
`endif
          end
        end
`ifdef PHASE_GLIDE_EN
        ST_GLIDING: begin
          // Sync has no effect here; only ticks move the glide along.
          if (tick) begin
            if (glide_diff <= STEP) begin
              inc_active <= inc_target;
              inc_ready  <= 1'b1;
              state      <= ST_READY;
            end else if (glide_up) begin
              inc_active <= inc_active + STEP;
            end else begin
              inc_active <= inc_active - STEP;
            end
          end
        end
`endif
        default: begin
          inc_ready <= 1'b1;
          state     <= ST_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_phase_accumulator
//
// Directed self-checking bench for phase_accumulator with ACC_W=16, INC_W=16,
// DIV=4 (default build, glide disabled). Inputs change on the falling edge;
// outputs are sampled on the falling edge, half a period after the active
// rising edge.
// ---------------------------------------------------------------------------
module tb_phase_accumulator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] inc_in;
  logic        inc_valid;
  logic        inc_ready;
  logic        sync;
  logic [7:0]  subsample_phase;
  logic        phase_wrap;
  logic        sample_tick;

  int checks = 0;
  int errors = 0;

  phase_accumulator #(
    .ACC_W(16),
    .INC_W(16),
    .DIV(4),
    .GLIDE_STEP(16'h0010)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .inc_in(inc_in),
    .inc_valid(inc_valid),
    .inc_ready(inc_ready),
    .sync(sync),
    .subsample_phase(subsample_phase),
    .phase_wrap(phase_wrap),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all handshake/control inputs at once.
  task automatic applyStimulus(input logic en, input logic vld,
                               input logic [15:0] inc, input logic syn);
    enable    = en;
    inc_valid = vld;
    inc_in    = inc;
    sync      = syn;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n clock cycles, ending at a falling edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Advance to the sample point just after the next tick, bounded.
  task automatic nextTick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 16);
    checkOutput("tick_seen", {15'd0, sample_tick}, 16'd1);
  endtask

  task automatic checkPhase(input string tag, input logic [7:0] ph,
                            input logic wr);
    checkOutput({tag, "_phase"}, {8'd0, subsample_phase}, {8'd0, ph});
    checkOutput({tag, "_wrap"}, {15'd0, phase_wrap}, {15'd0, wr});
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    cycles(2);
    checkPhase("reset", 8'h00, 1'b0);
    checkOutput("reset_tick", {15'd0, sample_tick}, 16'd0);
    checkOutput("reset_ready", {15'd0, inc_ready}, 16'd1);

    // Free run, no increment: tick on every 4th edge, phase stays 0
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cycles(1);
      checkOutput("idle_tick", {15'd0, sample_tick}, (i % 4 == 0) ? 16'd1 : 16'd0);
      checkOutput("idle_phase", {8'd0, subsample_phase}, 16'h0000);
      checkOutput("idle_ready", {15'd0, inc_ready}, 16'd1);
    end

    // Load 0x0100: transfer tick leaves phase 0, then 1,2,3,4
    applyStimulus(1'b1, 1'b1, 16'h0100, 1'b0);
    cycles(1);
    checkOutput("load1_ready_low", {15'd0, inc_ready}, 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    nextTick();
    checkPhase("load1_xfer", 8'h00, 1'b0);
    checkOutput("load1_ready_high", {15'd0, inc_ready}, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      nextTick();
      checkPhase("ramp1", 8'(k), 1'b0);
    end

    // Load 0x4000 together with a sync: transfer tick zeroes the phase,
    // then 0x40, 0x80, 0xC0, 0x00 with a single-cycle wrap
    applyStimulus(1'b1, 1'b1, 16'h4000, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    nextTick();
    checkPhase("load2_xfer_sync", 8'h00, 1'b0);
    checkOutput("load2_ready_high", {15'd0, inc_ready}, 16'd1);
    nextTick();
    checkPhase("ramp2_a", 8'h40, 1'b0);
    nextTick();
    checkPhase("ramp2_b", 8'h80, 1'b0);
    nextTick();
    checkPhase("ramp2_c", 8'hC0, 1'b0);
    nextTick();
    checkPhase("ramp2_wrap", 8'h00, 1'b1);
    cycles(1);
    checkPhase("wrap_one_cycle", 8'h00, 1'b0);
    checkOutput("wrap_one_cycle_tick", {15'd0, sample_tick}, 16'd0);

    // Sync pulse at phase 0x80
    nextTick();
    checkPhase("pre_sync_a", 8'h40, 1'b0);
    nextTick();
    checkPhase("pre_sync_b", 8'h80, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    nextTick();
    checkPhase("sync_tick", 8'h00, 1'b0);
    nextTick();
    checkPhase("post_sync", 8'h40, 1'b0);

    // Sync asserted only on the tick cycle itself
    cycles(3);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("sync_on_tick_tick", {15'd0, sample_tick}, 16'd1);
    checkPhase("sync_on_tick", 8'h00, 1'b0);
    nextTick();
    checkPhase("post_sync2", 8'h40, 1'b0);

    // Pause for 10 cycles mid-ramp, loading 0x0200 during the pause
    cycles(2);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("pause_ready_low", {15'd0, inc_ready}, 16'd0);
    for (int j = 0; j < 9; j++) begin
      cycles(1);
      checkOutput("pause_tick", {15'd0, sample_tick}, 16'd0);
      checkOutput("pause_phase", {8'd0, subsample_phase}, 16'h0040);
    end
    checkOutput("pause_ready_held", {15'd0, inc_ready}, 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    cycles(1);
    checkOutput("resume_no_tick", {15'd0, sample_tick}, 16'd0);
    checkOutput("resume_ready_low", {15'd0, inc_ready}, 16'd0);
    cycles(1);
    checkOutput("resume_tick", {15'd0, sample_tick}, 16'd1);
    checkPhase("resume_xfer", 8'h80, 1'b0);
    checkOutput("resume_ready_high", {15'd0, inc_ready}, 16'd1);
    nextTick();
    checkPhase("new_inc_a", 8'h82, 1'b0);
    nextTick();
    checkPhase("new_inc_b", 8'h84, 1'b0);

    // Reset mid-operation with an increment and a sync pending
    applyStimulus(1'b1, 1'b1, 16'h1000, 1'b1);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkPhase("async_reset", 8'h00, 1'b0);
    checkOutput("async_reset_ready", {15'd0, inc_ready}, 16'd1);
    checkOutput("async_reset_tick", {15'd0, sample_tick}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    checkOutput("post_reset_no_tick", {15'd0, sample_tick}, 16'd0);
    cycles(1);
    checkOutput("post_reset_tick", {15'd0, sample_tick}, 16'd1);
    checkPhase("post_reset_a", 8'h00, 1'b0);
    checkOutput("post_reset_ready", {15'd0, inc_ready}, 16'd1);
    nextTick();
    checkPhase("post_reset_b", 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
